// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared predictor encodings and constants
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  // Instructions are word aligned, so PC bits [1:0] never index anything.
  localparam int PC_OFS = 2;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// rtl/branch_predictor_sat_counter2.sv - 2-bit saturating counter next-state function
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       inc_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (inc_i) begin
      if (cnt_i != CTR_ST) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != CTR_SNT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - PHT + direct-mapped BTB fetch predictor, EX-stage trained
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int PHT_BITS  = 6,
  parameter int BTB_BITS  = 5,
  parameter int HIST_BITS = 6,
  parameter int MODE      = 0,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      f_pc,
  output logic             p_taken,
  output logic             p_hit,
  output logic [31:0]      p_target,
  input  logic             u_valid,
  input  logic [31:0]      u_pc,
  input  logic             u_taken,
  input  logic [31:0]      u_target,
  input  logic             u_pred_taken,
  input  logic [31:0]      u_pred_target,
  output logic             mispredict,
  output logic [CNT_W-1:0] n_branches,
  output logic [CNT_W-1:0] n_mispred
);

  localparam int PHT_N = 1 << PHT_BITS;
  localparam int BTB_N = 1 << BTB_BITS;
  localparam int TAG_W = 32 - BTB_BITS - PC_OFS;

  logic [1:0]           pht_q       [PHT_N];
  logic                 btb_valid_q [BTB_N];
  logic [TAG_W-1:0]     btb_tag_q   [BTB_N];
  logic [31:0]          btb_tgt_q   [BTB_N];
  logic [HIST_BITS-1:0] ghr_q;
  logic [CNT_W-1:0]     n_br_q;
  logic [CNT_W-1:0]     n_mp_q;

  function automatic logic [PHT_BITS-1:0] pht_index(input logic [31:0] pc,
                                                   input logic [HIST_BITS-1:0] ghr);
    logic [PHT_BITS-1:0] idx;
    idx = pc[PC_OFS +: PHT_BITS];
    if (MODE == MODE_GSHARE) idx = idx ^ PHT_BITS'(ghr);
    return idx;
  endfunction

  // Fetch-side lookup: purely combinational off registered state, no bypass.
  logic [PHT_BITS-1:0] f_pht_idx;
  logic [BTB_BITS-1:0] f_btb_idx;
  logic [TAG_W-1:0]    f_tag;

  assign f_pht_idx = pht_index(f_pc, ghr_q);
  assign f_btb_idx = f_pc[PC_OFS +: BTB_BITS];
  assign f_tag     = f_pc[31 -: TAG_W];

  assign p_hit    = btb_valid_q[f_btb_idx] && (btb_tag_q[f_btb_idx] == f_tag);
  assign p_taken  = pht_q[f_pht_idx][1] & p_hit;
  assign p_target = btb_tgt_q[f_btb_idx];

  // Update-side indexing mirrors fetch, using the GHR of the current cycle.
  logic [PHT_BITS-1:0] u_pht_idx;
  logic [BTB_BITS-1:0] u_btb_idx;
  logic [1:0]          u_ctr_d;

  assign u_pht_idx = pht_index(u_pc, ghr_q);
  assign u_btb_idx = u_pc[PC_OFS +: BTB_BITS];

  sat_counter2 u_sat (
    .cnt_i (pht_q[u_pht_idx]),
    .inc_i (u_taken),
    .cnt_o (u_ctr_d)
  );

  assign mispredict = u_valid & ((u_taken != u_pred_taken) |
                                 (u_taken & (u_pred_target != u_target)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= CTR_WNT;
      for (int j = 0; j < BTB_N; j++) btb_valid_q[j] <= 1'b0;
      ghr_q  <= '0;
      n_br_q <= '0;
      n_mp_q <= '0;
    end else if (u_valid) begin
      pht_q[u_pht_idx] <= u_ctr_d;
      if (u_taken) btb_valid_q[u_btb_idx] <= 1'b1;
      if (MODE == MODE_GSHARE) ghr_q <= {ghr_q[HIST_BITS-2:0], u_taken};
      if (n_br_q != '1) n_br_q <= n_br_q + CNT_W'(1);
      if (mispredict && (n_mp_q != '1)) n_mp_q <= n_mp_q + CNT_W'(1);
    end
  end

  // Tag/target payload needs no reset; validity alone gates its use.
  always_ff @(posedge clk) begin
    if (rst_n && u_valid && u_taken) begin
      btb_tag_q[u_btb_idx] <= u_pc[31 -: TAG_W];
      btb_tgt_q[u_btb_idx] <= u_target;
    end
  end

  assign n_branches = n_br_q;
  assign n_mispred  = n_mp_q;

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{f_pc[PC_OFS-1:0], u_pc[PC_OFS-1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - bimodal and gshare predictors checked against a table-level reference model
module tb_branch_predictor;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] f_pc, u_pc, u_target, u_pred_target;
  logic        u_valid, u_taken, u_pred_taken;

  logic        ptk_b, hit_b, mp_b;
  logic [31:0] tgt_b, nbr_b, nmp_b;
  logic        ptk_g, hit_g, mp_g;
  logic [31:0] tgt_g;
  logic [3:0]  nbr_g, nmp_g;

  branch_predictor #(.MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .f_pc(f_pc),
    .p_taken(ptk_b), .p_hit(hit_b), .p_target(tgt_b),
    .u_valid(u_valid), .u_pc(u_pc), .u_taken(u_taken), .u_target(u_target),
    .u_pred_taken(u_pred_taken), .u_pred_target(u_pred_target),
    .mispredict(mp_b), .n_branches(nbr_b), .n_mispred(nmp_b)
  );

  // Gshare instance uses 2 history bits and 4-bit counters so saturation is reachable.
  branch_predictor #(.MODE(1), .HIST_BITS(2), .CNT_W(4)) dut_g (
    .clk(clk), .rst_n(rst_n), .f_pc(f_pc),
    .p_taken(ptk_g), .p_hit(hit_g), .p_target(tgt_g),
    .u_valid(u_valid), .u_pc(u_pc), .u_taken(u_taken), .u_target(u_target),
    .u_pred_taken(u_pred_taken), .u_pred_target(u_pred_target),
    .mispredict(mp_g), .n_branches(nbr_g), .n_mispred(nmp_g)
  );

  logic        ptk [2];
  logic        hit [2];
  logic        mp  [2];
  logic [31:0] tgt [2];
  logic [31:0] nbr [2];
  logic [31:0] nmp [2];

  always_comb begin
    ptk[0] = ptk_b; hit[0] = hit_b; mp[0] = mp_b; tgt[0] = tgt_b; nbr[0] = nbr_b; nmp[0] = nmp_b;
    ptk[1] = ptk_g; hit[1] = hit_g; mp[1] = mp_g; tgt[1] = tgt_g;
    nbr[1] = {28'd0, nbr_g}; nmp[1] = {28'd0, nmp_g};
  end

  // Reference model: m=0 bimodal, m=1 gshare with 2 history bits.
  int          ctr  [2][64];
  bit          bv   [2][32];
  int unsigned btag [2][32];
  logic [31:0] btgt [2][32];
  int          ghr  [2];
  longint      nb   [2];
  longint      nm   [2];
  longint      cap  [2] = '{64'hFFFF_FFFF, 15};

  int errors = 0;
  int checks = 0;

  function automatic int pidx(int m, logic [31:0] pc);
    int i;
    i = int'((pc >> 2) % 64);
    if (m == 1) i = i ^ (ghr[1] % 4);
    return i;
  endfunction

  function automatic int bidx(logic [31:0] pc);
    return int'((pc >> 2) % 32);
  endfunction

  function automatic bit m_hit(int m, logic [31:0] pc);
    return bv[m][bidx(pc)] && (btag[m][bidx(pc)] == int'(pc >> 7));
  endfunction

  function automatic bit m_taken(int m, logic [31:0] pc);
    return m_hit(m, pc) && (ctr[m][pidx(m, pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_tgt(int m, logic [31:0] pc);
    return btgt[m][bidx(pc)];
  endfunction

  function automatic bit m_mp();
    if (u_valid !== 1'b1) return 1'b0;
    return (u_taken != u_pred_taken) || (u_taken && (u_pred_target != u_target));
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 64; i++) ctr[m][i] = 1;
      for (int j = 0; j < 32; j++) begin bv[m][j] = 0; btag[m][j] = 0; btgt[m][j] = 0; end
      ghr[m] = 0; nb[m] = 0; nm[m] = 0;
    end
  endtask

  task automatic tick();
    bit mpv;
    int pi, bi;
    mpv = m_mp();
    if (rst_n !== 1'b1) model_reset();
    else if (u_valid === 1'b1) begin
      for (int m = 0; m < 2; m++) begin
        pi = pidx(m, u_pc);
        bi = bidx(u_pc);
        if (u_taken) begin
          ctr[m][pi] = (ctr[m][pi] < 3) ? ctr[m][pi] + 1 : 3;
          bv[m][bi] = 1; btag[m][bi] = int'(u_pc >> 7); btgt[m][bi] = u_target;
        end else begin
          ctr[m][pi] = (ctr[m][pi] > 0) ? ctr[m][pi] - 1 : 0;
        end
        if (m == 1) ghr[1] = ((ghr[1] << 1) | int'(u_taken)) % 4;
        if (nb[m] < cap[m]) nb[m]++;
        if (mpv && nm[m] < cap[m]) nm[m]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                       input bit pt, input logic [31:0] ptg, input logic [31:0] fpc);
    f_pc = fpc;
    u_valid = v;
    if (v) begin
      u_pc = pc; u_taken = tk; u_target = tg; u_pred_taken = pt; u_pred_target = ptg;
    end else begin
      u_pc = 'x; u_taken = 1'bx; u_target = 'x; u_pred_taken = 1'bx; u_pred_target = 'x;
    end
    #1;
  endtask

  task automatic idle(input logic [31:0] fpc);
    drive(0, 0, 0, 0, 0, 0, fpc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(32'h0040_0000);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    idle(32'h0040_0000);
    for (int m = 0; m < 2; m++) begin
      checks++; if (hit[m] !== 1'b0) begin errors++; $display("FAIL reset_p_hit m=%0d got=%b exp=0", m, hit[m]); end
      checks++; if (ptk[m] !== 1'b0) begin errors++; $display("FAIL reset_p_taken m=%0d got=%b exp=0", m, ptk[m]); end
      checks++; if (nbr[m] !== 32'd0) begin errors++; $display("FAIL reset_n_branches m=%0d got=%0d exp=0", m, nbr[m]); end
      checks++; if (nmp[m] !== 32'd0) begin errors++; $display("FAIL reset_n_mispred m=%0d got=%0d exp=0", m, nmp[m]); end
    end
  endtask

  task automatic test_bimodal_train();
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h0040_0010, 1, 32'h0040_0100, 0, 32'h0, 32'h0040_0010);
      checks++; if (mp_b !== 1'b1) begin errors++; $display("FAIL train_mispredict k=%0d got=%b exp=1", k, mp_b); end
      checks++; if (mp_g !== m_mp()) begin errors++; $display("FAIL train_mispredict_g k=%0d got=%b exp=%b", k, mp_g, m_mp()); end
      tick();
      idle(32'h0040_0010);
      checks++; if (ptk_b !== 1'b1) begin errors++; $display("FAIL train_p_taken k=%0d got=%b exp=1", k, ptk_b); end
      checks++; if (ptk_g !== m_taken(1, f_pc)) begin errors++; $display("FAIL train_p_taken_g k=%0d got=%b exp=%b", k, ptk_g, m_taken(1, f_pc)); end
    end
    checks++; if (nmp_b !== 32'd3) begin errors++; $display("FAIL train_n_mispred got=%0d exp=3", nmp_b); end
    checks++; if (nbr_b !== 32'd3) begin errors++; $display("FAIL train_n_branches got=%0d exp=3", nbr_b); end
    checks++; if (hit_b !== 1'b1) begin errors++; $display("FAIL train_p_hit got=%b exp=1", hit_b); end
    checks++; if (tgt_b !== 32'h0040_0100) begin errors++; $display("FAIL train_p_target got=%h exp=00400100", tgt_b); end
  endtask

  task automatic test_desaturate();
    for (int k = 0; k < 2; k++) begin
      drive(1, 32'h0040_0010, 0, 32'h0, 1, 32'h0, 32'h0040_0010);
      tick();
      idle(32'h0040_0010);
      checks++; if (ptk_b !== (k == 0)) begin errors++; $display("FAIL desat_p_taken k=%0d got=%b exp=%b", k, ptk_b, k == 0); end
      checks++; if (hit_b !== 1'b1) begin errors++; $display("FAIL desat_p_hit k=%0d got=%b exp=1", k, hit_b); end
    end
  endtask

  task automatic test_alias();
    drive(1, 32'h0040_0090, 1, 32'h0040_0200, 0, 32'h0, 32'h0040_0010);
    tick();
    idle(32'h0040_0010);
    checks++; if (hit_b !== 1'b0) begin errors++; $display("FAIL alias_old_hit got=%b exp=0", hit_b); end
    idle(32'h0040_0090);
    checks++; if (hit_b !== 1'b1) begin errors++; $display("FAIL alias_new_hit got=%b exp=1", hit_b); end
    checks++; if (tgt_b !== 32'h0040_0200) begin errors++; $display("FAIL alias_target got=%h exp=00400200", tgt_b); end
    checks++; if (ptk_b !== 1'b1) begin errors++; $display("FAIL alias_p_taken got=%b exp=1", ptk_b); end
  endtask

  task automatic test_same_cycle();
    drive(1, 32'h0040_0090, 0, 32'h0, 1, 32'h0, 32'h0040_0090);
    checks++; if (ptk_b !== 1'b1) begin errors++; $display("FAIL same_cycle_old got=%b exp=1", ptk_b); end
    tick();
    idle(32'h0040_0090);
    checks++; if (ptk_b !== 1'b0) begin errors++; $display("FAIL same_cycle_new got=%b exp=0", ptk_b); end
  endtask

  task automatic test_gshare();
    logic [31:0] pc;
    bit          tk, pred;
    pc = 32'h0040_0040;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tk = (k % 2 == 0);
      pred = m_taken(1, pc);
      drive(1, pc, tk, 32'h0040_0400, pred, m_tgt(1, pc), pc);
      checks++; if (ptk_g !== pred) begin errors++; $display("FAIL gshare_p_taken k=%0d got=%b exp=%b", k, ptk_g, pred); end
      if (k >= 4) begin
        checks++; if (mp_g !== 1'b0) begin errors++; $display("FAIL gshare_mispredict k=%0d got=%b exp=0", k, mp_g); end
      end
      tick();
    end
    idle(pc);
    checks++; if (ptk_g !== 1'b1) begin errors++; $display("FAIL gshare_context got=%b exp=1", ptk_g); end
    checks++; if (nmp_g !== 4'd2) begin errors++; $display("FAIL gshare_n_mispred got=%0d exp=2", nmp_g); end
  endtask

  task automatic test_random();
    logic [31:0] pc, fpc, tg;
    bit          v;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      pc  = 32'h0040_0000 + ($urandom_range(0, 3) << 7) + ($urandom_range(0, 7) << 2);
      fpc = 32'h0040_0000 + ($urandom_range(0, 3) << 7) + ($urandom_range(0, 7) << 2);
      tg  = 32'h0050_0000 + ($urandom_range(0, 3) << 2);
      drive(v, pc, 1'($urandom_range(0, 1)), tg, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) != 0) ? tg : 32'h0050_0000, fpc);
      for (int m = 0; m < 2; m++) begin
        checks++; if (hit[m] !== m_hit(m, fpc)) begin errors++; $display("FAIL rand_p_hit n=%0d m=%0d got=%b exp=%b", n, m, hit[m], m_hit(m, fpc)); end
        checks++; if (ptk[m] !== m_taken(m, fpc)) begin errors++; $display("FAIL rand_p_taken n=%0d m=%0d got=%b exp=%b", n, m, ptk[m], m_taken(m, fpc)); end
        if (m_hit(m, fpc)) begin
          checks++; if (tgt[m] !== m_tgt(m, fpc)) begin errors++; $display("FAIL rand_p_target n=%0d m=%0d got=%h exp=%h", n, m, tgt[m], m_tgt(m, fpc)); end
        end
        checks++; if (mp[m] !== m_mp()) begin errors++; $display("FAIL rand_mispredict n=%0d m=%0d got=%b exp=%b", n, m, mp[m], m_mp()); end
        checks++; if (nbr[m] !== 32'(nb[m])) begin errors++; $display("FAIL rand_n_branches n=%0d m=%0d got=%0d exp=%0d", n, m, nbr[m], nb[m]); end
        checks++; if (nmp[m] !== 32'(nm[m])) begin errors++; $display("FAIL rand_n_mispred n=%0d m=%0d got=%0d exp=%0d", n, m, nmp[m], nm[m]); end
      end
      tick();
    end
  endtask

  task automatic test_reset_collision();
    drive(1, 32'h0040_0010, 1, 32'h0040_0100, 0, 32'h0, 32'h0040_0010);
    tick();
    rst_n = 1'b0;
    drive(1, 32'h0040_0010, 1, 32'h0040_0100, 0, 32'h0, 32'h0040_0010);
    tick();
    rst_n = 1'b1;
    idle(32'h0040_0010);
    for (int m = 0; m < 2; m++) begin
      checks++; if (hit[m] !== 1'b0) begin errors++; $display("FAIL rstcol_p_hit m=%0d got=%b exp=0", m, hit[m]); end
      checks++; if (nbr[m] !== 32'd0) begin errors++; $display("FAIL rstcol_n_branches m=%0d got=%0d exp=0", m, nbr[m]); end
      checks++; if (nmp[m] !== 32'd0) begin errors++; $display("FAIL rstcol_n_mispred m=%0d got=%0d exp=0", m, nmp[m]); end
    end
    drive(1, 32'h0040_0010, 1, 32'h0040_0100, 1, 32'h0040_0100, 32'h0040_0010);
    tick();
    idle(32'h0040_0010);
    checks++; if (ptk_b !== 1'b1) begin errors++; $display("FAIL rstcol_retrain got=%b exp=1", ptk_b); end
    checks++; if (nbr_b !== 32'd1) begin errors++; $display("FAIL rstcol_count got=%0d exp=1", nbr_b); end
    checks++; if (ptk_g !== m_taken(1, f_pc)) begin errors++; $display("FAIL rstcol_p_taken_g got=%b exp=%b", ptk_g, m_taken(1, f_pc)); end
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_bimodal_train();
    test_desaturate();
    test_alias();
    test_same_cycle();
    test_gshare();
    test_random();
    test_reset_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor: a pattern history table (PHT) of 2-bit saturating counters plus a direct-mapped branch target buffer (BTB).
- Successor to the combinational branch-taken decision. The EX-stage resolved outcome (taken, target) trains the tables; fetch receives a next-cycle prediction.
- MODE selects the index function: bimodal (PC only) or gshare (PC XOR global history).
- Flags mispredictions and keeps performance counters.

Parameters:
- PHT_BITS, 6: log2 of PHT entries (64).
- BTB_BITS, 5: log2 of BTB entries (32).
- HIST_BITS, 6: global history length; must be <= PHT_BITS.
- MODE, 0: 0 = bimodal, 1 = gshare.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- f_pc  in  32  fetch PC
- p_taken  out  1  predicted direction
- p_hit  out  1  BTB hit for f_pc
- p_target  out  32  predicted target (valid when p_hit)
- u_valid  in  1  resolved branch this cycle
- u_pc  in  32  PC of the resolved branch
- u_taken  in  1  actual direction (from branch-taken logic)
- u_target  in  32  actual target
- u_pred_taken  in  1  direction predicted at fetch, piped to EX
- u_pred_target  in  32  target predicted at fetch, piped to EX
- mispredict  out  1  combinational redirect request
- n_branches  out  CNT_W  resolved-branch count
- n_mispred  out  CNT_W  misprediction count

Behaviour:
- Reset: on the clk edge with rst_n=0:
  - all PHT counters := 2'b01 (weakly not-taken)
  - all BTB valid := 0; tags/targets don't-care
  - GHR := 0; n_branches := 0; n_mispred := 0
  - Reset mid-operation discards any u_valid in that cycle.
- Indexing:
  - PHT index = f_pc[PHT_BITS+1:2]. In gshare mode, the low HIST_BITS of the index are XORed with GHR.
  - BTB index = f_pc[BTB_BITS+1:2]; tag = f_pc[31:BTB_BITS+2].
  - The update path uses the same functions on u_pc, with the GHR value current in that cycle.
- Lookup:
  - Combinational from registered state; zero-cycle latency.
  - p_hit = valid & tag match.
  - p_taken = counter[1] & p_hit. A BTB miss always predicts not-taken.
- Update (clk edge, u_valid=1, rst_n=1):
  - Counter: +1 if u_taken (saturate at 3), else -1 (saturate at 0).
  - BTB: if u_taken, write valid=1, tag, and u_target. A not-taken branch never allocates or invalidates.
  - Gshare: GHR := {GHR[HIST_BITS-2:0], u_taken}. The GHR is not updated speculatively and does not move in bimodal mode.
  - n_branches += 1.
- Same-cycle lookup and update to the same entry: lookup returns the pre-update value (no bypass). The new value is visible from the next cycle.
- mispredict = u_valid & ((u_taken != u_pred_taken) | (u_taken & u_pred_target != u_target)). When asserted, n_mispred += 1 on that edge.
- Perf counters saturate at all-ones; they never wrap.
- u_valid=0: no state changes.
- X on u_* while u_valid=0 must not propagate into state.

Decomposition:
- Shared include alongside the ISA definitions:
  - counter encodings SNT=00, WNT=01, WT=10, ST=11
  - mode constants MODE_BIMODAL / MODE_GSHARE
  - PC word-offset constant (2)
- Sub-module sat_counter2: 2-bit saturating next-state function (inc/dec). It is instantiated once on the update path.
- PHT and BTB are plain register arrays in the top module, written on one port and read on one port.

Test Plan:
- Reset, then lookup f_pc=0x00400000 → p_hit=0, p_taken=0, p_target ignored; n_branches=0, n_mispred=0.
- Bimodal: 3× u_valid with u_pc=0x00400010, u_taken=1, u_target=0x00400100, u_pred_taken=0.
  - Counter steps 01→10→11→11 (saturates).
  - mispredict=1 each time → n_mispred=3.
  - Lookup f_pc=0x00400010 → p_hit=1, p_taken=1, p_target=0x00400100.
- Counter de-saturation: from ST, apply two not-taken updates → p_taken=1 after the first, 0 after the second; the BTB entry stays valid.
- Alias and same-cycle access:
  - Update 0x00400010 then 0x00400090 (same BTB index, different tag, taken) → 0x00400010 now misses.
  - Same-cycle lookup+update of one entry shows the old counter, and the new one the next cycle.
- Gshare (MODE=1, HIST_BITS=2):
  - Alternate taken/not-taken on one PC for 8 updates → the two history contexts train to opposite states.
  - Predictions then match the outcome each time; mispredict=0 for the final 4.
- Reset asserted in the same cycle as u_valid=1 → counters back to 01, BTB invalid, GHR=0, counters 0; the update is lost.
